// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that owns a shared bank of D latches: setup, enable pulse, hold per write.
// Optional latch readback check is enabled by defining LATCH_READBACK_EN.
module latch_write_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
`ifdef LATCH_READBACK_EN
    input  logic [WIDTH-1:0]   latch_q,
    output logic               err,
    output logic [IDW-1:0]     err_id,
`endif
    output logic [N-1:0]       ack,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic [WIDTH-1:0]   latch_d,
    output logic               latch_en
);

    localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             turn_reg, turn_next;
    logic [WIDTH-1:0] data_reg;
    logic [IDW-1:0]   grant_reg;
    logic [N-1:0]     ack_reg;
    logic             busy_reg;
    logic             latch_en_reg;

    logic [WIDTH-1:0] slice [N];
    logic             found;
    logic [IDW-1:0]   pick;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First requester at or above the pointer, wrapping modulo N.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_reg) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        turn_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // The IDLE cycle right after HOLD is a turnaround: it lets the acked
                // requester withdraw req before a new grant is considered.
                if (!turn_reg && found) begin
                    state_next = SETUP;
                    if (int'(pick) == N - 1) ptr_next = '0;
                    else                     ptr_next = pick + IDW'(1);
                end
            end
            SETUP: begin
                state_next = ENABLE;
                cnt_next   = CW'(EN_CYCLES - 1);
            end
            ENABLE: begin
                if (cnt_reg == '0) state_next = HOLD;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            HOLD: begin
                state_next = IDLE;
                turn_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            turn_reg     <= 1'b0;
            data_reg     <= '0;
            grant_reg    <= '0;
            ack_reg      <= '0;
            busy_reg     <= 1'b0;
            latch_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            turn_reg     <= turn_next;
            busy_reg     <= (state_next != IDLE);
            latch_en_reg <= (state_next == ENABLE);
            // Data is committed at grant; later wdata changes are ignored.
            if (state_reg == IDLE && state_next == SETUP) begin
                data_reg  <= slice[pick];
                grant_reg <= pick;
            end
            ack_reg <= '0;
            if (state_next == HOLD) ack_reg[grant_reg] <= 1'b1;
        end
    end

`ifdef LATCH_READBACK_EN
    logic           err_reg;
    logic [IDW-1:0] err_id_reg;

    // Sticky: only the first failing write is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg    <= 1'b0;
            err_id_reg <= '0;
        end else if (state_reg == HOLD && latch_q != data_reg && !err_reg) begin
            err_reg    <= 1'b1;
            err_id_reg <= grant_reg;
        end
    end

    assign err    = err_reg;
    assign err_id = err_id_reg;
`endif

    assign ack      = ack_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;
    assign latch_d  = data_reg;
    assign latch_en = latch_en_reg;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed literal scenarios plus randomized traffic
// compared every cycle against a transaction-phase model.
module tb_latch_write_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int EN    = 2;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       ack;
    logic               busy;
    logic [IDW-1:0]     grant_id;
    logic [WIDTH-1:0]   latch_d;
    logic               latch_en;
`ifdef LATCH_READBACK_EN
    logic [WIDTH-1:0]   latch_q;
    logic               err;
    logic [IDW-1:0]     err_id;
    logic               q_zero;
    assign latch_q = q_zero ? '0 : latch_d;
`endif

    latch_write_arbiter #(.N(N), .WIDTH(WIDTH), .EN_CYCLES(EN)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wdata(wdata),
`ifdef LATCH_READBACK_EN
        .latch_q(latch_q),
        .err(err),
        .err_id(err_id),
`endif
        .ack(ack),
        .busy(busy),
        .grant_id(grant_id),
        .latch_d(latch_d),
        .latch_en(latch_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is a phase count since its grant edge.
    // Phase 1 setup, 2..1+EN enable, 2+EN ack, 3+EN turnaround idle, 0 ready.
    int               m_phase = 0;
    int               m_ptr   = 0;
    int               m_grant = 0;
    logic [WIDTH-1:0] m_data  = '0;
    bit               m_valid = 0;
    bit               m_err   = 0;
    int               m_err_id = 0;

    always @(posedge clk) begin
        bit found;
        int j;
        m_valid = 1;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_grant = 0; m_data = '0;
            m_err = 0; m_err_id = 0;
        end else begin
`ifdef LATCH_READBACK_EN
            if (m_phase == 2 + EN && latch_q !== m_data && !m_err) begin
                m_err = 1; m_err_id = m_grant;
            end
`endif
            if (m_phase == 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && req[j]) begin
                        found   = 1;
                        m_grant = j;
                        m_data  = wdata[j*WIDTH +: WIDTH];
                        m_ptr   = (j + 1) % N;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 3 + EN) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_ack;
        if (m_valid) begin
            exp_ack = '0;
            if (m_phase == 2 + EN) exp_ack[m_grant] = 1'b1;
            chk("model_busy", busy, (m_phase >= 1 && m_phase <= 2 + EN));
            chk("model_latch_en", latch_en, (m_phase >= 2 && m_phase <= 1 + EN));
            chk("model_ack", ack, exp_ack);
            chk("model_grant_id", grant_id, m_grant);
            chk("model_latch_d", latch_d, m_data);
`ifdef LATCH_READBACK_EN
            chk("model_err", err, m_err);
            chk("model_err_id", err_id, m_err_id);
`endif
        end
    end

    int           ack_k [8];
    logic [N-1:0] ack_v [8];
    int           n_acks;

    task automatic record_acks(input int ncyc);
        n_acks = 0;
        for (int i = 0; i < 8; i++) begin ack_k[i] = -1; ack_v[i] = '0; end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (ack != '0 && n_acks < 8) begin
                ack_k[n_acks] = k;
                ack_v[n_acks] = ack;
                n_acks++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] drop_pending;
        rst = 1'b1; req = '0; wdata = '0;
`ifdef LATCH_READBACK_EN
        q_zero = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        // Reset state.
        chk("reset_busy", busy, 0);
        chk("reset_latch_en", latch_en, 0);
        chk("reset_ack", ack, 0);
        chk("reset_latch_d", latch_d, 0);
        rst = 1'b0;

        // Single write from requester 1, then wdata altered after grant.
        req = 4'b0010;
        wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_latch_d_k%0d", k), latch_d, (k >= 1) ? 8'hA5 : 8'h00);
            chk($sformatf("t1_latch_en_k%0d", k), latch_en, (k == 2 || k == 3));
            chk($sformatf("t1_ack_k%0d", k), ack, (k == 4) ? 4'b0010 : 4'b0000);
            if (k == 1) wdata = {8'h11, 8'h22, 8'h5A, 8'h33};
            if (k == 4) req = '0;
        end
        $display("t1 single write done, grant_id=%0d latch_d=%0h", grant_id, latch_d);

        // All four requesting: rotation 0,1,2,3,0 with six-cycle spacing.
        do_reset();
        req = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        record_acks(32);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_ack_cycle_%0d", i), ack_k[i], 4 + 6 * i);
            chk($sformatf("t2_ack_value_%0d", i), ack_v[i], 4'b0001 << (i % 4));
        end
        $display("t2 rotation done, acks=%0d", n_acks);

        // Reset during ENABLE, then a normal grant to requester 2.
        do_reset();
        req = 4'b0010;
        wdata = {8'h00, 8'h77, 8'h99, 8'h00};
        for (int k = 0; k <= 2; k++) @(negedge clk);
        chk("t4_en_before_rst", latch_en, 1);
        chk("t4_grant_before_rst", grant_id, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_en_after_rst", latch_en, 0);
        chk("t4_busy_after_rst", busy, 0);
        chk("t4_ack_after_rst", ack, 0);
        chk("t4_grant_after_rst", grant_id, 0);
        rst = 1'b0;
        req = 4'b0100;
        @(negedge clk);
        chk("t4_grant_new", grant_id, 2);
        chk("t4_latch_d_new", latch_d, 8'h77);
        repeat (3) @(negedge clk);
        chk("t4_ack_new", ack, 4'b0100);
        req = '0;
        $display("t4 reset mid-write done, ack=%0b", ack);

        // Request held after ack: second write six cycles later.
        do_reset();
        req = 4'b0001;
        wdata = {8'h00, 8'h00, 8'h00, 8'h3C};
        record_acks(14);
        req = '0;
        chk("t5_first_ack_cycle", ack_k[0], 4);
        chk("t5_second_ack_cycle", ack_k[1], 10);
        chk("t5_first_ack_value", ack_v[0], 4'b0001);
        chk("t5_second_ack_value", ack_v[1], 4'b0001);
        $display("t5 held request done, acks=%0d", n_acks);

`ifdef LATCH_READBACK_EN
        // Readback mismatch: sticky error with the granted id.
        do_reset();
        q_zero = 1'b1;
        req = 4'b0100;
        wdata = {8'h00, 8'h3C, 8'h00, 8'h00};
        for (int k = 0; k <= 5; k++) @(negedge clk);
        chk("t6_err", err, 1);
        chk("t6_err_id", err_id, 2);
        q_zero = 1'b0;
        req = 4'b0001;
        repeat (8) @(negedge clk);
        req = '0;
        chk("t6_err_sticky", err, 1);
        chk("t6_err_id_sticky", err_id, 2);
        $display("t6 readback done, err=%0b err_id=%0d", err, err_id);
`endif

        // Randomized traffic: requesters drop req the cycle after their ack.
        do_reset();
        drop_pending = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (drop_pending[i]) begin
                    req[i] = 1'b0;
                    drop_pending[i] = 1'b0;
                end else if (ack[i]) begin
                    drop_pending[i] = ($urandom_range(3) != 0);
                end else if (!req[i]) begin
                    req[i] = ($urandom_range(3) == 0);
                end
            end
            wdata = {$urandom, $urandom};
            rst = ($urandom_range(299) == 0);
`ifdef LATCH_READBACK_EN
            q_zero = ($urandom_range(99) == 0);
`endif
            if (c % 500 == 0) $display("random cycle %0d checks=%0d", c, checks);
        end
        rst = 1'b0;
        req = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
